// File: rtl/rock_setpoint_ctrl.sv
// Amplitude/frequency setpoint controller for the rocker drive.
// It steps A and F from button levels, with auto-repeat, saturation and optional periodic A decay.
module rock_setpoint_ctrl #(
    parameter int WIDTH         = 4,
    parameter int A_INIT        = 5,
    parameter int F_INIT        = 5,
    parameter int A_MAX         = 15,
    parameter int F_MAX         = 15,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4,
    parameter int DECAY_PERIOD  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_up,
    input  logic             a_down,
    input  logic             f_up,
    input  logic             f_down,
    input  logic             decay_en,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] F,
    output logic             F0,
    output logic             AF0,
    output logic             upd
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);
    localparam int DCW  = $clog2(DECAY_PERIOD + 1);

    logic [1:0] up_lvl, dn_lvl, step_up, step_dn;
    assign up_lvl = {f_up, a_up};
    assign dn_lvl = {f_down, a_down};

    // Channel 0 is A, channel 1 is F. The repeat counter counts down to the next auto-repeat step.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic           up_eff, dn_eff, press, rpt_hit;
            logic           up_prev_q, dn_prev_q;
            logic [RCW-1:0] rpt_q, rpt_d;

            assign up_eff  = up_lvl[gi] & ~dn_lvl[gi];
            assign dn_eff  = dn_lvl[gi] & ~up_lvl[gi];
            assign press   = (up_eff & ~up_prev_q) | (dn_eff & ~dn_prev_q);
            assign rpt_hit = (up_eff | dn_eff) & ~press & (rpt_q == '0);

            always_comb begin
                rpt_d = '0;
                if (press)
                    rpt_d = RCW'(REPEAT_DELAY - 1);
                else if (rpt_hit)
                    rpt_d = RCW'(REPEAT_PERIOD - 1);
                else if (up_eff | dn_eff)
                    rpt_d = rpt_q - 1'b1;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    up_prev_q <= 1'b0;
                    dn_prev_q <= 1'b0;
                    rpt_q     <= '0;
                end else begin
                    up_prev_q <= up_eff;
                    dn_prev_q <= dn_eff;
                    rpt_q     <= rpt_d;
                end
            end

            assign step_up[gi] = up_eff & (press | rpt_hit);
            assign step_dn[gi] = dn_eff & (press | rpt_hit);
        end
    endgenerate

    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic             tick;
    logic [WIDTH-1:0] a_q, a_d, f_q, f_d;
    logic             upd_q;

    assign tick   = decay_en && (dcnt_q == DCW'(DECAY_PERIOD - 1));
    assign dcnt_d = (decay_en && !tick) ? dcnt_q + 1'b1 : '0;

    // A decay tick cancels a simultaneous up step and merges with a down step.
    always_comb begin
        a_d = a_q;
        if (tick) begin
            if (!step_up[0] && a_q != '0)
                a_d = a_q - 1'b1;
        end else if (step_up[0] && a_q != WIDTH'(A_MAX)) begin
            a_d = a_q + 1'b1;
        end else if (step_dn[0] && a_q != '0) begin
            a_d = a_q - 1'b1;
        end
    end

    always_comb begin
        f_d = f_q;
        if (step_up[1] && f_q != WIDTH'(F_MAX))
            f_d = f_q + 1'b1;
        else if (step_dn[1] && f_q != '0)
            f_d = f_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= WIDTH'(A_INIT);
            f_q    <= WIDTH'(F_INIT);
            upd_q  <= 1'b0;
            dcnt_q <= '0;
        end else begin
            a_q    <= a_d;
            f_q    <= f_d;
            upd_q  <= (a_d != a_q) || (f_d != f_q);
            dcnt_q <= dcnt_d;
        end
    end

    assign A   = a_q;
    assign F   = f_q;
    assign upd = upd_q;
    assign F0  = (f_q == '0);
    assign AF0 = (a_q == '0) && (f_q == '0);

endmodule

// File: tb/tb_rock_setpoint_ctrl.sv
// Self-checking bench for rock_setpoint_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the setpoint rules.
module tb_rock_setpoint_ctrl;

    localparam int WIDTH = 4, A_INIT = 5, F_INIT = 5, A_MAX = 15, F_MAX = 15;
    localparam int RD = 8, RP = 4, DP = 16;

    logic clk = 1'b0;
    logic reset = 1'b1, a_up = 1'b0, a_down = 1'b0, f_up = 1'b0, f_down = 1'b0, decay_en = 1'b0;
    logic [WIDTH-1:0] A, F;
    logic F0, AF0, upd;

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    int m_a, m_f, m_upd, m_dcnt;
    int m_dir[2];
    int m_k[2];

    rock_setpoint_ctrl #(
        .WIDTH(WIDTH), .A_INIT(A_INIT), .F_INIT(F_INIT), .A_MAX(A_MAX), .F_MAX(F_MAX),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .DECAY_PERIOD(DP)
    ) dut (
        .clk(clk), .reset(reset), .a_up(a_up), .a_down(a_down), .f_up(f_up), .f_down(f_down),
        .decay_en(decay_en), .A(A), .F(F), .F0(F0), .AF0(AF0), .upd(upd)
    );

    always #5 clk = ~clk;

    function automatic int chan_step(int ch, bit up, bit dn);
        int dir;
        dir = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
        if (dir == 0) begin
            m_dir[ch] = 0;
            return 0;
        end
        if (dir != m_dir[ch]) begin
            m_dir[ch] = dir;
            m_k[ch]   = 0;
            return dir;
        end
        m_k[ch]++;
        if (m_k[ch] == RD || (m_k[ch] > RD && (m_k[ch] - RD) % RP == 0))
            return dir;
        return 0;
    endfunction

    task automatic model_step();
        int sa, sf, na, nf;
        bit dtick;
        if (reset) begin
            m_a = A_INIT; m_f = F_INIT; m_upd = 0; m_dcnt = 0;
            m_dir[0] = 0; m_dir[1] = 0;
            return;
        end
        sa = chan_step(0, a_up, a_down);
        sf = chan_step(1, f_up, f_down);
        dtick = 0;
        if (decay_en) begin
            m_dcnt++;
            if (m_dcnt == DP) begin
                dtick = 1;
                m_dcnt = 0;
            end
        end else begin
            m_dcnt = 0;
        end
        if (dtick)
            na = (sa == 1) ? m_a : ((m_a > 0) ? m_a - 1 : 0);
        else
            na = (m_a + sa > A_MAX) ? A_MAX : ((m_a + sa < 0) ? 0 : m_a + sa);
        nf = (m_f + sf > F_MAX) ? F_MAX : ((m_f + sf < 0) ? 0 : m_f + sf);
        m_upd = (na != m_a || nf != m_f) ? 1 : 0;
        m_a = na;
        m_f = nf;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (A !== 4'd5 || F !== 4'd5 || upd !== 1'b0 || F0 !== 1'b0 || AF0 !== 1'b0)
            $display("FAIL reset_state: A=%0d F=%0d upd=%0b F0=%0b AF0=%0b, required A=5 F=5 upd=0 F0=0 AF0=0",
                     A, F, upd, F0, AF0);
        else passes++;
    endtask

    task automatic test_single_pulse();
        a_down = 1'b1;
        tick();
        a_down = 1'b0;
        checks++;
        if (A !== 4'd4 || upd !== 1'b1 || F !== 4'd5 || F0 !== 1'b0)
            $display("FAIL single_pulse: A=%0d upd=%0b F=%0d F0=%0b, required A=4 upd=1 F=5 F0=0", A, upd, F, F0);
        else passes++;
        tick();
        checks++;
        if (upd !== 1'b0) $display("FAIL single_pulse_upd_drop: upd=%0b, required 0", upd);
        else passes++;
    endtask

    task automatic test_auto_repeat();
        int n;
        do_reset();
        n = 0;
        f_up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (upd === 1'b1) n++;
            checks++;
            if (F !== 4'(m_f)) $display("FAIL repeat_cycle%0d: F=%0d, required %0d", i, F, m_f);
            else passes++;
        end
        f_up = 1'b0;
        checks++;
        if (F !== 4'd9 || n != 4) $display("FAIL auto_repeat: F=%0d upd_pulses=%0d, required F=9 pulses=4", F, n);
        else passes++;
    endtask

    task automatic test_floor();
        int n;
        do_reset();
        n = 0;
        for (int i = 0; i < 7; i++) begin
            f_down = 1'b1;
            tick();
            if (upd === 1'b1) n++;
            f_down = 1'b0;
            tick();
        end
        checks++;
        if (F !== 4'd0 || F0 !== 1'b1 || n != 5)
            $display("FAIL f_floor: F=%0d F0=%0b upd_pulses=%0d, required F=0 F0=1 pulses=5", F, F0, n);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            a_down = 1'b1;
            tick();
            a_down = 1'b0;
            tick();
        end
        checks++;
        if (A !== 4'd0 || AF0 !== 1'b1) $display("FAIL a_floor: A=%0d AF0=%0b, required A=0 AF0=1", A, AF0);
        else passes++;
    endtask

    task automatic test_saturation();
        int n;
        a_up = 1'b1;
        for (int i = 0; i < 70; i++) tick();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (upd === 1'b1) n++;
        end
        checks++;
        if (A !== 4'd15 || n != 0) $display("FAIL a_ceiling: A=%0d upd_pulses=%0d, required A=15 pulses=0", A, n);
        else passes++;
        a_down = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (upd === 1'b1) n++;
        end
        a_up = 1'b0;
        a_down = 1'b0;
        checks++;
        if (A !== 4'd15 || n != 0) $display("FAIL both_pressed: A=%0d upd_pulses=%0d, required A=15 pulses=0", A, n);
        else passes++;
    endtask

    task automatic test_decay();
        do_reset();
        decay_en = 1'b1;
        for (int i = 0; i < 48; i++) tick();
        decay_en = 1'b0;
        checks++;
        if (A !== 4'd2) $display("FAIL decay_48: A=%0d, required 2", A);
        else passes++;
        do_reset();
        decay_en = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        a_up = 1'b1;
        tick();
        checks++;
        if (A !== 4'd5 || upd !== 1'b0) $display("FAIL decay_vs_up: A=%0d upd=%0b, required A=5 upd=0", A, upd);
        else passes++;
        a_up = 1'b0;
        decay_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        f_up = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (F !== 4'd7) $display("FAIL hold_before_reset: F=%0d, required 7", F);
        else passes++;
        reset = 1'b1;
        tick();
        checks++;
        if (F !== 4'd5) $display("FAIL reset_mid_hold: F=%0d, required 5", F);
        else passes++;
        reset = 1'b0;
        tick();
        checks++;
        if (F !== 4'd6 || upd !== 1'b1) $display("FAIL repress_after_reset: F=%0d upd=%0b, required F=6 upd=1", F, upd);
        else passes++;
        f_up = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) a_up = ~a_up;
            if ($urandom_range(7) == 0) a_down = ~a_down;
            if ($urandom_range(7) == 0) f_up = ~f_up;
            if ($urandom_range(7) == 0) f_down = ~f_down;
            if ($urandom_range(19) == 0) decay_en = ~decay_en;
            reset = ($urandom_range(149) == 0);
            tick();
            checks++;
            if (A !== 4'(m_a) || F !== 4'(m_f) || upd !== 1'(m_upd) ||
                F0 !== (m_f == 0) || AF0 !== (m_a == 0 && m_f == 0)) begin
                if (bad < 10)
                    $display("FAIL random_cycle%0d: A=%0d F=%0d upd=%0b F0=%0b AF0=%0b, required A=%0d F=%0d upd=%0d F0=%0b AF0=%0b",
                             i, A, F, upd, F0, AF0, m_a, m_f, m_upd, m_f == 0, m_a == 0 && m_f == 0);
                bad++;
            end else passes++;
        end
        reset = 1'b0;
        a_up = 1'b0; a_down = 1'b0; f_up = 1'b0; f_down = 1'b0; decay_en = 1'b0;
    endtask

    initial begin
        m_dir[0] = 0; m_dir[1] = 0; m_k[0] = 0; m_k[1] = 0;
        m_a = A_INIT; m_f = F_INIT; m_upd = 0; m_dcnt = 0;
        #2;
        test_reset();
        test_single_pulse();
        test_auto_repeat();
        test_floor();
        test_saturation();
        test_decay();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rock_setpoint_ctrl.md
Name: rock_setpoint_ctrl

Overview:
Parametrised amplitude/frequency setpoint controller for the rocker drive. It holds the amplitude (A) and frequency (F) setpoints. Both can be stepped up and down from button-level inputs, with edge detection, auto-repeat while a button is held, and saturation at the limits. An optional decay mode lowers A by one step at a fixed period. Its outputs feed the motor timing generator and the status/zero indicators.

Parameters:
WIDTH, 4, bit width of A and F
A_INIT, 5, A value loaded on reset
F_INIT, 5, F value loaded on reset
A_MAX, 15, upper saturation limit for A (≤ 2^WIDTH-1)
F_MAX, 15, upper saturation limit for F (≤ 2^WIDTH-1)
REPEAT_DELAY, 8, cycles from press step to first auto-repeat step (≥1)
REPEAT_PERIOD, 4, cycles between subsequent auto-repeat steps (≥1)
DECAY_PERIOD, 16, decay_en-high cycles per automatic A decrement (≥1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
a_up  in  1  amplitude-increase button level (debounced, clk-synchronous)
a_down  in  1  amplitude-decrease button level
f_up  in  1  frequency-increase button level
f_down  in  1  frequency-decrease button level
decay_en  in  1  enables periodic automatic A decrement
A  out  WIDTH  amplitude setpoint, registered
F  out  WIDTH  frequency setpoint, registered
F0  out  1  F == 0, combinational from the F register
AF0  out  1  (A == 0) && (F == 0), combinational from the registers
upd  out  1  one-cycle pulse: A or F changed value on the previous edge

Behaviour:
- Decided: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset (sampled high at an edge): A=A_INIT, F=F_INIT, upd=0. All repeat and decay counters are cleared, and the button history registers are cleared to 0.
- Effective request per channel: up_eff = up & ~down; dn_eff = down & ~up. If both are high, the channel does not step and its repeat counter is cleared.
- Press: an edge where the effective request is high and the previous-cycle effective request was low. The step is applied at that same edge, so the register updates 0 cycles after the first sampling edge.
- A button already high when reset deasserts counts as a press on the first non-reset edge.
- Auto-repeat: each channel has its own hold counter, starting at 0 on the press edge. While the same direction stays held, extra steps occur at press+REPEAT_DELAY and then every REPEAT_PERIOD cycles. Release or a direction change clears the counter, and a direction change counts as a new press.
- Arithmetic: a step is ±1, saturating. Up at *_MAX leaves the value unchanged, and down at 0 leaves it unchanged. No wrap-around. Hold counters and the repeat timing still run while saturated.
- Decay: the counter increments each cycle decay_en=1 and clears when decay_en=0. A tick occurs on the DECAY_PERIOD-th consecutive high cycle, then the counter restarts.
  - On a tick, A decrements by 1, saturating at 0.
  - A tick with a user A-up step in the same cycle: net no change.
  - A tick with a user A-down step: a single −1 only.
  - F is unaffected by decay.
- upd is registered: it goes high for one cycle after any edge where A or F changed value. It stays low when a step saturates.
- Reset mid-hold or mid-decay: counters clear and values reload. A held button re-presses after reset deasserts.

Test Plan:
- Reset, then a single a_down pulse (1 cycle) → A=4, upd high for 1 cycle, F=5, F0=0.
- f_up held 20 cycles from F=5 → steps at press+0, +8, +12, +16; F=9; upd pulses 4 times.
- f_down pulsed 7 times from F=5 → F=0, F0=1; the last 2 pulses produce no upd. Then a_down ×5 → A=0, AF0=1.
- a_up held at A=15 for 30 cycles → A stays 15, upd never asserted. a_up and a_down both high → no change.
- decay_en high 48 cycles from A=5 → ticks at cycles 16, 32, 48; A=2. A tick coinciding with an a_up press → A unchanged at that edge.
- reset asserted while f_up is held mid-repeat (F=7) → F=5 on the reset edge. f_up still high after reset deasserts → F=6 on the first non-reset edge.
